coinc_hist_binner: RTL and testbench

Parametrised successor to the photon-coincidence address distributer. It synchronises the data_arrived strobe and classifies each coincidence event from START/END detector codes into a histogram bin (CENTER, CENTER-INTERVAL, CENTER+INTERVAL). It then accumulates counts in an internal dual-port histogram RAM using a read-modify-write pipeline with forwarding. It sits between the TDC/interval front end and the host readout logic, and provides clear, readout and diagnostic counters.

---
 rtl/coinc_hist_binner.sv | 208 ++++++++++++++++++++
 tb/tb_coinc_hist_binner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_hist_binner.sv
// Coincidence histogram binner: synchronises the event strobe, classifies
// START/END codes into a bin and accumulates counts in an internal RAM.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   START, END        detector codes sampled on the synchronised rise
//   INTERVAL          measured delay in bins
//   data_arrived      asynchronous event strobe (rising edge = one event)
//   clear_req         pulse: drain the pipeline, then zero every bin
//   rd_addr, rd_data  readout port, one cycle latency, usable in any state
//   Addr, Memory_add  last accepted bin and its one-cycle accept pulse
//   busy              high while draining or clearing
//   invalid_cnt       events with an unrecognised START/END combination
//   oor_cnt           events whose bin falls outside the histogram
//   drop_cnt          valid events discarded while busy
module coinc_hist_binner #(
    parameter int INT_W  = 6,
    parameter int ADDR_W = 7,
    parameter int CENTER = 64,
    parameter int CNT_W  = 16,
    parameter int DIAG_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        START,
    input  logic [1:0]        END,
    input  logic [INT_W-1:0]  INTERVAL,
    input  logic              data_arrived,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] Addr,
    output logic              Memory_add,
    output logic              busy,
    output logic [DIAG_W-1:0] invalid_cnt,
    output logic [DIAG_W-1:0] oor_cnt,
    output logic [DIAG_W-1:0] drop_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    // Wide enough that CENTER +/- INTERVAL never wraps; the top bit is the sign.
    localparam int SW = ((INT_W > ADDR_W) ? INT_W : ADDR_W) + 2;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        DRAIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_idx;

    logic [2:0]        sync;
    logic              rise;
    logic              cls_ok;
    logic              in_range;
    logic              ev_ok;
    logic              accept;
    logic [SW-1:0]     center_w;
    logic [SW-1:0]     iv_w;
    logic [SW-1:0]     bin;

    logic [CNT_W-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]  a_q;
    logic              byp;
    logic [CNT_W-1:0]  byp_d;
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [CNT_W-1:0]  s2_src;
    logic [CNT_W-1:0]  s2_inc;
    logic              s3_valid;
    logic [ADDR_W-1:0] s3_addr;
    logic [CNT_W-1:0]  s3_data;

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [CNT_W-1:0]  wd;

    function automatic logic [DIAG_W-1:0] sat_inc(input logic [DIAG_W-1:0] v);
        return (v == '1) ? v : v + DIAG_W'(1);
    endfunction

    assign rise     = sync[1] & ~sync[2];
    assign center_w = SW'(CENTER);
    assign iv_w     = SW'(INTERVAL);
    assign busy     = (state_q != ACCUM);

    always_comb begin
        cls_ok = 1'b1;
        bin    = center_w;
        unique case (1'b1)
            (START == 2'b00 && END == 2'b11):
                bin = center_w;
            ((START == 2'b11 || START == 2'b01) && END == 2'b10):
                bin = center_w - iv_w;
            ((START == 2'b11 || START == 2'b10) && END == 2'b01):
                bin = center_w + iv_w;
            default:
                cls_ok = 1'b0;
        endcase
    end

    // Negative results set the sign bit, overflows set bits above ADDR_W.
    assign in_range = (bin[SW-1:ADDR_W] == '0);
    assign ev_ok    = rise & cls_ok & in_range;
    assign accept   = ev_ok & ~busy;

    // The read issued in S1 may coincide with the S3 write of the same bin
    // (events two cycles apart); that case is captured in byp. A direct
    // S3->S2 match covers back-to-back events and takes priority.
    always_comb begin
        s2_src = byp ? byp_d : a_q;
        if (s3_valid && s3_addr == s2_addr) begin
            s2_src = s3_data;
        end
    end

    assign s2_inc = (s2_src == '1) ? s2_src : s2_src + CNT_W'(1);

    // Port A is owned by the sweep while clearing; DRAIN guarantees no
    // increment is still in flight at that point.
    always_comb begin
        we = s3_valid;
        wa = s3_addr;
        wd = s3_data;
        if (state_q == CLEAR) begin
            we = 1'b1;
            wa = clr_idx;
            wd = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: begin
                if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (clear_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!Memory_add && !s2_valid && !s3_valid) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        a_q     <= mem[Addr];
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync        <= '0;
            Addr        <= '0;
            Memory_add  <= 1'b0;
            byp         <= 1'b0;
            byp_d       <= '0;
            s2_valid    <= 1'b0;
            s2_addr     <= '0;
            s3_valid    <= 1'b0;
            s3_addr     <= '0;
            s3_data     <= '0;
            invalid_cnt <= '0;
            oor_cnt     <= '0;
            drop_cnt    <= '0;
            state_q     <= CLEAR;
            clr_idx     <= '0;
        end else begin
            sync       <= {sync[1:0], data_arrived};
            Memory_add <= accept;
            if (accept) begin
                Addr <= bin[ADDR_W-1:0];
            end
            byp      <= s3_valid && (s3_addr == Addr);
            byp_d    <= s3_data;
            s2_valid <= Memory_add;
            s2_addr  <= Addr;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            s3_data  <= s2_inc;
            if (rise && !cls_ok) begin
                invalid_cnt <= sat_inc(invalid_cnt);
            end
            if (rise && cls_ok && !in_range) begin
                oor_cnt <= sat_inc(oor_cnt);
            end
            if (ev_ok && busy) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            state_q <= state_d;
            clr_idx <= (state_q == CLEAR) ? clr_idx + ADDR_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_coinc_hist_binner.sv
// Directed testbench for coinc_hist_binner: default instance plus
// CENTER=10 and CNT_W=4 variants sharing one stimulus stream.
module tb_coinc_hist_binner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_c = 2'b00;
    logic [1:0]  end_c = 2'b00;
    logic [5:0]  interval = '0;
    logic        da = 1'b0;
    logic        clear_req = 1'b0;
    logic [6:0]  rd_addr = '0;

    logic [15:0] rd_data_m;
    logic [6:0]  addr_m;
    logic        madd_m, busy_m;
    logic [15:0] inv_m, oor_m, drop_m;

    logic [15:0] rd_data_c;
    logic [6:0]  addr_c;
    logic        madd_c, busy_c;
    logic [15:0] inv_c, oor_c, drop_c;

    logic [3:0]  rd_data_s;
    logic [6:0]  addr_s;
    logic        madd_s, busy_s;
    logic [15:0] inv_s, oor_s, drop_s;

    int checks = 0;
    int errors = 0;
    bit seen;
    bit held;

    coinc_hist_binner dut (
        .clk(clk), .rst(rst), .START(start_c), .END(end_c),
        .INTERVAL(interval), .data_arrived(da), .clear_req(clear_req),
        .rd_addr(rd_addr), .rd_data(rd_data_m), .Addr(addr_m),
        .Memory_add(madd_m), .busy(busy_m), .invalid_cnt(inv_m),
        .oor_cnt(oor_m), .drop_cnt(drop_m)
    );

    coinc_hist_binner #(.CENTER(10)) dut_c (
        .clk(clk), .rst(rst), .START(start_c), .END(end_c),
        .INTERVAL(interval), .data_arrived(da), .clear_req(clear_req),
        .rd_addr(rd_addr), .rd_data(rd_data_c), .Addr(addr_c),
        .Memory_add(madd_c), .busy(busy_c), .invalid_cnt(inv_c),
        .oor_cnt(oor_c), .drop_cnt(drop_c)
    );

    coinc_hist_binner #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .START(start_c), .END(end_c),
        .INTERVAL(interval), .data_arrived(da), .clear_req(clear_req),
        .rd_addr(rd_addr), .rd_data(rd_data_s), .Addr(addr_s),
        .Memory_add(madd_s), .busy(busy_s), .invalid_cnt(inv_s),
        .oor_cnt(oor_s), .drop_cnt(drop_s)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic rd(input logic [6:0] a);
        @(negedge clk) rd_addr = a;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] s, input logic [1:0] e,
                        input logic [5:0] iv, output bit sn, output bit hd);
        @(negedge clk);
        start_c = s; end_c = e; interval = iv; da = 1'b1;
        @(negedge clk) da = 1'b0;
        sn = 1'b0;
        hd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (madd_m) begin
                sn = 1'b1;
                break;
            end
        end
        @(negedge clk) hd = madd_m;
        repeat (4) @(negedge clk);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) da = 1'b1;
            @(negedge clk) da = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_m && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_m) begin
            errors++;
            $display("FAIL idle_timeout busy=%0d want 0", busy_m);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL rst_busy got %0d want 1", busy_m); end
        checks++; if (addr_m !== 7'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", addr_m); end
        checks++; if (madd_m !== 1'b0) begin errors++; $display("FAIL rst_madd got %0d want 0", madd_m); end
        checks++; if (inv_m !== 16'd0) begin errors++; $display("FAIL rst_inv got %0d want 0", inv_m); end
        checks++; if (oor_m !== 16'd0) begin errors++; $display("FAIL rst_oor got %0d want 0", oor_m); end
        checks++; if (drop_m !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", drop_m); end
        rst = 1'b0;
        n = 0;
        while (busy_m && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 128) begin errors++; $display("FAIL busy_len got %0d want 128", n); end
        rd(7'd0);
        checks++; if (rd_data_m !== 16'd0) begin errors++; $display("FAIL bin0_init got %0d want 0", rd_data_m); end
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd0) begin errors++; $display("FAIL bin64_init got %0d want 0", rd_data_m); end
        rd(7'd127);
        checks++; if (rd_data_m !== 16'd0) begin errors++; $display("FAIL bin127_init got %0d want 0", rd_data_m); end
    endtask

    task automatic test_center();
        send(2'b00, 2'b11, 6'd9, seen, held);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL center_pulse got %0d want 1", seen); end
        checks++; if (held !== 1'b0) begin errors++; $display("FAIL center_pulse_len got %0d want 0", held); end
        checks++; if (addr_m !== 7'd64) begin errors++; $display("FAIL center_addr got %0d want 64", addr_m); end
        checks++; if (addr_c !== 7'd10) begin errors++; $display("FAIL center_addr_c10 got %0d want 10", addr_c); end
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd1) begin errors++; $display("FAIL center_bin got %0d want 1", rd_data_m); end
    endtask

    task automatic test_plusminus();
        send(2'b01, 2'b10, 6'd5, seen, held);
        checks++; if (addr_m !== 7'd59) begin errors++; $display("FAIL minus_addr got %0d want 59", addr_m); end
        checks++; if (addr_c !== 7'd5) begin errors++; $display("FAIL minus_addr_c10 got %0d want 5", addr_c); end
        send(2'b10, 2'b01, 6'd5, seen, held);
        checks++; if (addr_m !== 7'd69) begin errors++; $display("FAIL plus_addr got %0d want 69", addr_m); end
        checks++; if (addr_c !== 7'd15) begin errors++; $display("FAIL plus_addr_c10 got %0d want 15", addr_c); end
        rd(7'd59);
        checks++; if (rd_data_m !== 16'd1) begin errors++; $display("FAIL minus_bin got %0d want 1", rd_data_m); end
        rd(7'd69);
        checks++; if (rd_data_m !== 16'd1) begin errors++; $display("FAIL plus_bin got %0d want 1", rd_data_m); end
    endtask

    task automatic test_range();
        send(2'b01, 2'b10, 6'd63, seen, held);
        checks++; if (addr_m !== 7'd1) begin errors++; $display("FAIL low_edge_addr got %0d want 1", addr_m); end
        checks++; if (oor_c !== 16'd1) begin errors++; $display("FAIL oor_c10_a got %0d want 1", oor_c); end
        send(2'b01, 2'b10, 6'd20, seen, held);
        checks++; if (addr_m !== 7'd44) begin errors++; $display("FAIL minus20_addr got %0d want 44", addr_m); end
        checks++; if (oor_c !== 16'd2) begin errors++; $display("FAIL oor_c10_b got %0d want 2", oor_c); end
        checks++; if (addr_c !== 7'd15) begin errors++; $display("FAIL oor_addr_hold got %0d want 15", addr_c); end
        send(2'b11, 2'b01, 6'd63, seen, held);
        checks++; if (addr_m !== 7'd127) begin errors++; $display("FAIL high_edge_addr got %0d want 127", addr_m); end
        send(2'b10, 2'b01, 6'd0, seen, held);
        checks++; if (addr_m !== 7'd64) begin errors++; $display("FAIL zero_iv_addr got %0d want 64", addr_m); end
        send(2'b00, 2'b00, 6'd5, seen, held);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL invalid_pulse got %0d want 0", seen); end
        checks++; if (inv_m !== 16'd1) begin errors++; $display("FAIL invalid_cnt got %0d want 1", inv_m); end
        checks++; if (oor_m !== 16'd0) begin errors++; $display("FAIL oor_m got %0d want 0", oor_m); end
        checks++; if (addr_m !== 7'd64) begin errors++; $display("FAIL invalid_addr_hold got %0d want 64", addr_m); end
        rd(7'd1);
        checks++; if (rd_data_m !== 16'd1) begin errors++; $display("FAIL bin1 got %0d want 1", rd_data_m); end
        rd(7'd127);
        checks++; if (rd_data_m !== 16'd1) begin errors++; $display("FAIL bin127 got %0d want 1", rd_data_m); end
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd2) begin errors++; $display("FAIL bin64_two got %0d want 2", rd_data_m); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk) clear_req = 1'b1;
        @(negedge clk) clear_req = 1'b0;
        wait_idle();
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd0) begin errors++; $display("FAIL cleared_bin64 got %0d want 0", rd_data_m); end
        start_c = 2'b00; end_c = 2'b11; interval = 6'd0;
        burst(10);
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd10) begin errors++; $display("FAIL fwd_bin64 got %0d want 10", rd_data_m); end
        checks++; if (rd_data_s !== 4'd10) begin errors++; $display("FAIL fwd_bin64_w4 got %0d want 10", rd_data_s); end
        burst(10);
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd20) begin errors++; $display("FAIL fwd_bin64_20 got %0d want 20", rd_data_m); end
        checks++; if (rd_data_s !== 4'd15) begin errors++; $display("FAIL sat_bin64_w4 got %0d want 15", rd_data_s); end
    endtask

    task automatic test_clear_drain();
        logic [15:0] mx;
        int nz;
        bit got;
        rd_addr = 7'd64;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) da = 1'b1;
            @(negedge clk) da = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (madd_m) begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL third_pulse got %0d want 1", got); end
        @(negedge clk) clear_req = 1'b1;
        @(negedge clk) clear_req = 1'b0;
        mx = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rd_data_m > mx) mx = rd_data_m;
            if (!busy_m && i > 2) break;
        end
        checks++; if (mx !== 16'd23) begin errors++; $display("FAIL drain_peak got %0d want 23", mx); end
        wait_idle();
        nz = 0;
        for (int a = 0; a < 128; a++) begin
            rd(7'(a));
            if (rd_data_m != 16'd0) nz++;
        end
        checks++; if (nz != 0) begin errors++; $display("FAIL nonzero_bins got %0d want 0", nz); end
    endtask

    task automatic test_drop();
        @(negedge clk) clear_req = 1'b1;
        @(negedge clk) clear_req = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL sweep_busy got %0d want 1", busy_m); end
        send(2'b00, 2'b11, 6'd9, seen, held);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drop_pulse got %0d want 0", seen); end
        checks++; if (drop_m !== 16'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", drop_m); end
        wait_idle();
        rd(7'd64);
        checks++; if (rd_data_m !== 16'd0) begin errors++; $display("FAIL drop_bin64 got %0d want 0", rd_data_m); end
        checks++; if (inv_m !== 16'd1) begin errors++; $display("FAIL inv_hold got %0d want 1", inv_m); end
    endtask

    initial begin
        test_reset();
        test_center();
        test_plusminus();
        test_range();
        test_back_to_back();
        test_clear_drain();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
